prio_code_decoder: RTL

Clocked receiving end of the 8-to-3 active-low priority encoder: takes the encoder's Y_bar/GS_bar code, qualifies it for stability, and decodes it back to an active-low one-hot request word. The word is delivered through a VLD/RDY handshake, with an overrun flag. It sits between the encoder outputs and the request-servicing logic. A request is reported once per assertion, not once per cycle.

---
 rtl/prio_code_decoder_pkg.sv | 24 ++
 rtl/dec_bin2onehot_bar.sv | 16 +
 rtl/prio_code_decoder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/prio_code_decoder_pkg.sv
// Shared definitions for the priority-code decoder.
//   state_t        : FSM states of the qualifier/handshake machine
//   CNT_W          : width of the stability counter
//   STABLE_MIN/MAX : legal range for the STABLE_CYCLES parameter
//   stable_cycles_ok() : range check used at elaboration
package prio_code_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    HOLD     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int CNT_W      = 4;
  localparam int STABLE_MIN = 2;
  // The counter must be able to reach STABLE_CYCLES.
  localparam int STABLE_MAX = (1 << CNT_W) - 1;

  function automatic bit stable_cycles_ok(input int n);
    return (n >= STABLE_MIN) && (n <= STABLE_MAX);
  endfunction

endpackage

// File: rtl/dec_bin2onehot_bar.sv
// Combinational binary to active-low one-hot decoder.
//   bin        : binary index, WIDTH_IN bits
//   onehot_bar : WIDTH_OUT bits, bit 'bin' low, all others high
module dec_bin2onehot_bar #(
  parameter int WIDTH_IN  = 3,
  parameter int WIDTH_OUT = 8
) (
  input  logic [WIDTH_IN-1:0]  bin,
  output logic [WIDTH_OUT-1:0] onehot_bar
);

  for (genvar gi = 0; gi < WIDTH_OUT; gi++) begin : g_bit
    assign onehot_bar[gi] = (bin != WIDTH_IN'(gi));
  end

endmodule

// File: rtl/prio_code_decoder.sv
// Receiving end of an active-low 8-to-3 priority encoder. The encoder code
// is sampled, qualified for STABLE_CYCLES identical valid samples, decoded
// to an active-low one-hot word and offered once per assertion through a
// VLD/RDY handshake.
//   CLK     : clock, rising edge
//   RST_bar : asynchronous active-low reset
//   EN_bar  : active-low enable; high invalidates the sample
//   GS_bar  : active-low group select; low means Y_bar is valid
//   Y_bar   : active-low encoded priority (code = ~Y_bar)
//   RDY     : consumer ready, honoured only while VLD=1
//   VLD     : D_bar holds a qualified request
//   D_bar   : decoded request, active-low one-hot
//   OVR     : sticky overrun, a different valid code arrived while holding
module prio_code_decoder
  import prio_code_decoder_pkg::*;
#(
  parameter int WIDTH_IN      = 3,
  parameter int WIDTH_OUT     = 8,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 RST_bar,
  input  logic                 EN_bar,
  input  logic                 GS_bar,
  input  logic [WIDTH_IN-1:0]  Y_bar,
  input  logic                 RDY,
  output logic                 VLD,
  output logic [WIDTH_OUT-1:0] D_bar,
  output logic                 OVR
);

  if (!stable_cycles_ok(STABLE_CYCLES)) begin : g_bad_stable
    $error("prio_code_decoder: STABLE_CYCLES out of range");
  end
  if (WIDTH_OUT != (1 << WIDTH_IN)) begin : g_bad_width
    $error("prio_code_decoder: WIDTH_OUT must equal 2**WIDTH_IN");
  end

  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Input sample stage
  logic                 samp_valid_reg;
  logic [WIDTH_IN-1:0]  samp_code_reg;

  // FSM state and datapath
  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [WIDTH_IN-1:0]  cand_reg, cand_next;
  logic                 vld_reg, vld_next;
  logic [WIDTH_OUT-1:0] d_bar_reg, d_bar_next;
  logic                 ovr_reg, ovr_next;

  logic [WIDTH_OUT-1:0] cand_onehot_bar;
  logic [CNT_W-1:0]     cnt_plus1;
  logic                 handshake;

  dec_bin2onehot_bar #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT)
  ) u_dec (
    .bin        (cand_reg),
    .onehot_bar (cand_onehot_bar)
  );

  assign cnt_plus1 = cnt_reg + CNT_ONE;
  // vld_reg is only ever set in HOLD, so RDY outside HOLD has no effect.
  assign handshake = vld_reg & RDY;

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      samp_valid_reg <= 1'b0;
      samp_code_reg  <= '0;
    end else begin
      samp_valid_reg <= ~EN_bar & ~GS_bar;
      samp_code_reg  <= ~Y_bar;
    end
  end

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      cand_reg  <= '0;
      vld_reg   <= 1'b0;
      d_bar_reg <= '1;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
      vld_reg   <= vld_next;
      d_bar_reg <= d_bar_next;
      ovr_reg   <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    vld_next   = vld_reg;
    d_bar_next = d_bar_reg;
    ovr_next   = ovr_reg;

    unique case (state_reg)
      IDLE: begin
        if (samp_valid_reg) begin
          state_next = QUAL;
          cnt_next   = CNT_ONE;
          cand_next  = samp_code_reg;
        end
      end

      QUAL: begin
        if (!samp_valid_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (samp_code_reg != cand_reg) begin
          cnt_next  = CNT_ONE;
          cand_next = samp_code_reg;
        end else begin
          cnt_next = cnt_plus1;
          if (cnt_plus1 == CNT_TARGET) begin
            // cand_reg equals the sample here, so its decode is the report.
            state_next = HOLD;
            vld_next   = 1'b1;
            d_bar_next = cand_onehot_bar;
          end
        end
      end

      HOLD: begin
        if (handshake) begin
          // Clearing OVR wins over a same-edge set; a differing code is
          // not lost because it is re-qualified from QUAL.
          vld_next   = 1'b0;
          d_bar_next = '1;
          ovr_next   = 1'b0;
          if (!samp_valid_reg) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (samp_code_reg == cand_reg) begin
            state_next = WAIT_REL;
          end else begin
            state_next = QUAL;
            cnt_next   = CNT_ONE;
            cand_next  = samp_code_reg;
          end
        end else if (samp_valid_reg && (samp_code_reg != cand_reg)) begin
          ovr_next = 1'b1;
        end
      end

      WAIT_REL: begin
        // Suppress re-reporting while the same request stays asserted.
        if (!samp_valid_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (samp_code_reg != cand_reg) begin
          state_next = QUAL;
          cnt_next   = CNT_ONE;
          cand_next  = samp_code_reg;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign VLD   = vld_reg;
  assign D_bar = d_bar_reg;
  assign OVR   = ovr_reg;

endmodule
